// File: rtl/and_gate_if.sv
// Valid/ready bundle between an and_gate unit and its parent.
// The master (parent) supplies the operands and drains the results.
interface and_gate_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             inv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             c_all;
  logic             c_zero;

  modport master (
    output in_valid, a, b, inv, out_ready,
    input  in_ready, out_valid, c, c_all, c_zero
  );

  modport slave (
    input  in_valid, a, b, inv, out_ready,
    output in_ready, out_valid, c, c_all, c_zero
  );
endinterface

// File: rtl/and_gate.sv
// Registered AND/NAND unit with reduction flags behind a 2-entry elastic output FIFO.
// Define AND_GATE_STATS_EN to add a saturating accepted-transfer counter on op_count.
module and_gate #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  and_gate_if.slave   bus
`ifdef AND_GATE_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);

  logic [WIDTH-1:0] dataMem [2];
  logic             allMem  [2];
  logic             zeroMem [2];
  logic             headPtr;
  logic             tailPtr;
  logic [1:0]       count;

  logic [WIDTH-1:0] cReg;
  logic             cAllReg;
  logic             cZeroReg;

  logic [WIDTH-1:0] result;
  logic             resultAll;
  logic             resultZero;
  logic             accept;
  logic             emit;
  logic             nextHead;
  logic [1:0]       nextCount;
  logic [WIDTH-1:0] nextData;
  logic             nextAll;
  logic             nextZero;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.c         = cReg;
  assign bus.c_all     = cAllReg;
  assign bus.c_zero    = cZeroReg;

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = bus.out_valid & bus.out_ready;

  always_comb begin
    result     = bus.inv ? ~(bus.a & bus.b) : (bus.a & bus.b);
    resultAll  = &result;
    resultZero = ~|result;
  end

  // The presented head for the next cycle may be the entry written this very
  // cycle (accept into an empty FIFO, or accept+emit at count 1).
  always_comb begin
    nextHead  = emit ? ~headPtr : headPtr;
    nextCount = count;
    if (accept && !emit) begin
      nextCount = count + 2'd1;
    end else if (emit && !accept) begin
      nextCount = count - 2'd1;
    end
    if (accept && (nextHead == tailPtr)) begin
      nextData = result;
      nextAll  = resultAll;
      nextZero = resultZero;
    end else begin
      nextData = dataMem[nextHead];
      nextAll  = allMem[nextHead];
      nextZero = zeroMem[nextHead];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr    <= 1'b0;
      tailPtr    <= 1'b0;
      count      <= 2'd0;
      dataMem[0] <= '0;
      dataMem[1] <= '0;
      allMem[0]  <= 1'b0;
      allMem[1]  <= 1'b0;
      zeroMem[0] <= 1'b1;
      zeroMem[1] <= 1'b1;
      cReg       <= '0;
      cAllReg    <= 1'b0;
      cZeroReg   <= 1'b1;
    end else begin
      if (accept) begin
        dataMem[tailPtr] <= result;
        allMem[tailPtr]  <= resultAll;
        zeroMem[tailPtr] <= resultZero;
        tailPtr          <= ~tailPtr;
      end
      headPtr <= nextHead;
      count   <= nextCount;
      // When the FIFO drains, the outputs keep showing the last emitted result.
      if (nextCount != 2'd0) begin
        cReg     <= nextData;
        cAllReg  <= nextAll;
        cZeroReg <= nextZero;
      end
    end
  end

`ifdef AND_GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= 16'd0;
    end else if (accept && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed self-checking bench for and_gate at WIDTH=8.
// Build with AND_GATE_STATS_EN defined to also exercise op_count.
module tb_and_gate;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   compareCount;
  int   failCount;

  and_gate_if #(.WIDTH(WIDTH)) bus ();

`ifdef AND_GATE_STATS_EN
  logic [15:0] op_count;
`endif

  and_gate #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef AND_GATE_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic iinv,
                               input logic ordy);
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.inv       = iinv;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ov, input logic ir,
                          input logic [WIDTH-1:0] cv, input logic ca, input logic cz);
    checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    checkOutput({tag, ".in_ready"},  64'(bus.in_ready),  64'(ir));
    checkOutput({tag, ".c"},         64'(bus.c),         64'(cv));
    checkOutput({tag, ".c_all"},     64'(bus.c_all),     64'(ca));
    checkOutput({tag, ".c_zero"},    64'(bus.c_zero),    64'(cz));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] re;
    compareCount = 0;
    failCount    = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.inv      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkAll("reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Basic AND, one-cycle latency.
    applyStimulus(1'b1, 8'hF0, 8'h3C, 1'b0, 1'b1);
    checkAll("and_f0_3c", 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);

    // All-ones result, then NAND of the same operands with simultaneous emit.
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    checkAll("and_ff_ff", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkAll("nand_ff_ff", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkAll("drain_hold", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Backpressure: two accepts fill the FIFO, the third is held.
    applyStimulus(1'b1, 8'hAA, 8'h0F, 1'b0, 1'b0);
    checkAll("bp_acc1", 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF0, 8'hFF, 1'b0, 1'b0);
    checkAll("bp_acc2", 1'b1, 1'b0, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0);
    checkAll("bp_held", 1'b1, 1'b0, 8'h0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b1, 1'b1);
    checkAll("bp_emit1", 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b1, 1'b1);
    checkAll("bp_emit2", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkAll("bp_emit3", 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Full throughput with random operands.
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      re = ra & rb;
      applyStimulus(1'b1, ra, rb, 1'b0, 1'b1);
      checkAll($sformatf("stream%0d", i), 1'b1, 1'b1, re, &re, ~|re);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("stream_drain.out_valid", 64'(bus.out_valid), 64'd0);

    // Reset while full discards both stored results.
    applyStimulus(1'b1, 8'h55, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0F, 8'hFF, 1'b0, 1'b0);
    checkOutput("full.in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    reset = 1'b0;
    checkAll("rst_full", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkAll("rst_full_after1", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkAll("rst_full_after2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

`ifdef AND_GATE_STATS_EN
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("stats_reset0", 64'(op_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(i), 8'hFF, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("stats_five", 64'(op_count), 64'd5);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("stats_reset1", 64'(op_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
